cpu_fetch_queue: RTL

//  Parametrised instruction prefetch unit for the multi-cycle RV32I core. Fetches sequential words

---
 rtl/cpu_fetch_queue.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: sequential instruction prefetcher for the multi-cycle RV32I core.
// Keeps up to DEPTH fetched words (or in-order fault markers) ahead of execution and
// issues at most one bus read at a time. A redirect flushes the queue and restarts
// fetch; a read already in flight at that moment is drained and its data dropped.
module cpu_fetch_queue #(
   parameter logic [31:0] EXEC_START_ADDR = 32'h4000_0000,
   parameter int          DEPTH           = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] ma_addr,
   output logic        ma_rd_req,
   output logic [3:0]  ma_data_mask,
   input  logic [31:0] ma_data_in,
   input  logic        ma_done,
   input  logic        ma_timeout,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   output logic        inst_fault_mis,
   input  logic        inst_ack
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,  // ready to issue the next fetch
      WAIT  = 2'd1,  // read in flight, result will be queued
      HALT  = 2'd2,  // fault queued, wait for the core to redirect
      DRAIN = 2'd3   // read in flight after a redirect, result is dropped
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       fpc_q;
   logic [31:0]       req_addr_q;
   logic              rd_req_q;
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  cnt_after_pop;

   // Queue storage, one field per array.
   logic [31:0]       word_mem  [DEPTH];
   logic [31:0]       pc_mem    [DEPTH];
   logic              fault_mem [DEPTH];
   logic              mis_mem   [DEPTH];

   logic              pop;
   logic              push;
   logic [31:0]       push_word;
   logic              push_fault;
   logic              push_mis;
   logic              issue;
   logic              rd_drop;
   logic              fpc_adv;

   assign pop           = inst_ack && (count_q != '0);
   assign cnt_after_pop = count_q - {{PTR_W{1'b0}}, pop};

   // Next-state and datapath control for the fetch sequencer.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can infer a latch.
      state_d    = state_q;
      push       = 1'b0;
      push_word  = ma_data_in;
      push_fault = 1'b0;
      push_mis   = 1'b0;
      issue      = 1'b0;
      rd_drop    = 1'b0;
      fpc_adv    = 1'b0;
      if (redirect) begin
         // A redirect discards any push/pop; an in-flight read must still complete.
         case (state_q)
            WAIT, DRAIN: begin
               if (ma_done || ma_timeout) begin
                  rd_drop = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = DRAIN;
               end
            end
            default: state_d = IDLE;
         endcase
      end else begin
         case (state_q)
            IDLE: begin
               if (cnt_after_pop < FULL) begin
                  if (fpc_q[1:0] == 2'b00) begin
                     issue   = 1'b1;
                     state_d = WAIT;
                  end else begin
                     push       = 1'b1;
                     push_word  = '0;
                     push_fault = 1'b1;
                     push_mis   = 1'b1;
                     state_d    = HALT;
                  end
               end
            end
            WAIT: begin
               if (ma_timeout) begin
                  rd_drop    = 1'b1;
                  push       = 1'b1;
                  push_word  = '0;
                  push_fault = 1'b1;
                  state_d    = HALT;
               end else if (ma_done) begin
                  rd_drop = 1'b1;
                  push    = 1'b1;
                  fpc_adv = 1'b1;
                  state_d = IDLE;
               end
            end
            HALT: ;
            DRAIN: begin
               if (ma_done || ma_timeout) begin
                  rd_drop = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Sequencer state, fetch PC, request latch and the address held on the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q    <= IDLE;
         fpc_q      <= EXEC_START_ADDR;
         req_addr_q <= EXEC_START_ADDR;
         rd_req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (redirect)     fpc_q <= redirect_pc;
         else if (fpc_adv) fpc_q <= fpc_q + 32'd4;
         if (issue) begin
            rd_req_q   <= 1'b1;
            req_addr_q <= fpc_q;
         end else if (rd_drop) begin
            rd_req_q <= 1'b0;
         end
      end
   end

   // Queue pointers and occupancy; redirect empties the queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (redirect) begin
         head_q  <= tail_q;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;
      end
   end

   // Entry storage write port.
   // NOTE: the storage array has no reset; count/head/tail alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         word_mem[tail_q]  <= push_word;
         pc_mem[tail_q]    <= fpc_q;
         fault_mem[tail_q] <= push_fault;
         mis_mem[tail_q]   <= push_mis;
      end
   end

   assign ma_addr        = req_addr_q;
   assign ma_rd_req      = rd_req_q;
   assign ma_data_mask   = 4'b1111;
   assign inst_valid     = (count_q != '0);
   assign inst           = word_mem[head_q];
   assign inst_pc        = pc_mem[head_q];
   assign inst_fault     = fault_mem[head_q];
   assign inst_fault_mis = mis_mem[head_q];

endmodule
